// File: rtl/dbus_timer_pkg.sv
// Shared types for the dbus_timer peripheral: register offsets, CTRL/STATUS
// bit positions and the CTRL register layout.
`timescale 1ns/1ps
package dbus_timer_pkg;

  typedef enum logic [1:0] {
    TMR_CTRL    = 2'd0,
    TMR_COUNT   = 2'd1,
    TMR_COMPARE = 2'd2,
    TMR_STATUS  = 2'd3
  } timer_reg_t;

  localparam int unsigned CTRL_EN_BIT       = 0;
  localparam int unsigned CTRL_AR_BIT       = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT   = 2;
  localparam int unsigned CTRL_PRESCALE_LSB = 8;
  localparam int unsigned STAT_MATCH_BIT    = 0;
  localparam int unsigned STAT_OVR_BIT      = 1;

  typedef struct packed {
    logic [7:0] prescale;
    logic [4:0] rsvd;
    logic       irq_en;
    logic       auto_reload;
    logic       en;
  } ctrl_t;

  // Reserved CTRL bits are never stored, so they always read back as zero.
  function automatic ctrl_t ctrl_from_word(input logic [15:0] w);
    ctrl_t c;
    c.prescale    = w[CTRL_PRESCALE_LSB +: 8];
    c.rsvd        = 5'd0;
    c.irq_en      = w[CTRL_IRQ_EN_BIT];
    c.auto_reload = w[CTRL_AR_BIT];
    c.en          = w[CTRL_EN_BIT];
    return c;
  endfunction

  function automatic logic [15:0] status_word(input logic match, input logic ovr);
    logic [15:0] s;
    s                 = 16'h0000;
    s[STAT_MATCH_BIT] = match;
    s[STAT_OVR_BIT]   = ovr;
    return s;
  endfunction

endpackage

// File: rtl/if_dbus.sv
// J1 data bus: word address, single-cycle read/write strobes, write and read data.
`timescale 1ns/1ps
interface if_dbus;
  logic [15:0] adr;
  logic        re;
  logic        we;
  logic [15:0] dat_o;
  logic [15:0] dat_i;

  modport master (output adr, output re, output we, output dat_o, input dat_i);
  modport slave  (input adr, input re, input we, input dat_o, output dat_i);
endinterface

// File: rtl/dbus_timer_prescaler.sv
// Prescaler for dbus_timer: one tick every PRESCALE+1 enabled cycles.
`timescale 1ns/1ps
module timer_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic       i_clr,
  input  logic [7:0] i_prescale,
  output logic       o_tick
);

  logic [7:0] r_pre;
  logic [7:0] w_pre_nxt;
  logic       w_hit;

  assign w_hit  = (r_pre == i_prescale);
  assign o_tick = i_en & w_hit;

  always_comb begin
    w_pre_nxt = r_pre;
    if (i_clr || !i_en || w_hit) begin
      w_pre_nxt = 8'd0;
    end else begin
      w_pre_nxt = r_pre + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= 8'd0;
    end else begin
      r_pre <= w_pre_nxt;
    end
  end

endmodule

// File: rtl/dbus_timer.sv
// Memory-mapped 16-bit timer/compare responder on the J1 data bus with a
// registered one-cycle read path and a registered level interrupt.
`timescale 1ns/1ps
module dbus_timer
  import dbus_timer_pkg::*;
#(
  parameter logic [15:0] BASE = 16'h4000
) (
  input  logic  clk,
  input  logic  reset,
  if_dbus.slave dbus,
  output logic  irq
);

  ctrl_t       r_ctrl;
  logic [15:0] r_count;
  logic [15:0] r_compare;
  logic        r_match;
  logic        r_ovr;
  logic [15:0] r_dat_i;
  logic        r_irq;

  ctrl_t       w_ctrl_nxt;
  logic [15:0] w_count_nxt;
  logic [15:0] w_compare_nxt;
  logic        w_match_nxt;
  logic        w_ovr_nxt;
  logic [15:0] w_dat_nxt;
  logic [15:0] w_rd_data;

  logic        w_sel;
  timer_reg_t  w_off;
  logic        w_wr_ctrl;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_wr_status;
  logic        w_tick;
  logic        w_cmp_eq;
  logic        w_match_evt;

  assign w_sel        = (dbus.adr[15:2] == BASE[15:2]);
  assign w_off        = timer_reg_t'(dbus.adr[1:0]);
  assign w_wr_ctrl    = dbus.we & w_sel & (w_off == TMR_CTRL);
  assign w_wr_count   = dbus.we & w_sel & (w_off == TMR_COUNT);
  assign w_wr_compare = dbus.we & w_sel & (w_off == TMR_COMPARE);
  assign w_wr_status  = dbus.we & w_sel & (w_off == TMR_STATUS);

  timer_prescaler u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .i_en       (r_ctrl.en),
    .i_clr      (w_wr_ctrl),
    .i_prescale (r_ctrl.prescale),
    .o_tick     (w_tick)
  );

  // A COUNT write in the tick cycle suppresses both the increment and the compare.
  assign w_cmp_eq    = (r_count == r_compare);
  assign w_match_evt = w_tick & ~w_wr_count & w_cmp_eq;

  always_comb begin
    w_ctrl_nxt = r_ctrl;
    if (w_wr_ctrl) begin
      w_ctrl_nxt = ctrl_from_word(dbus.dat_o);
    end else if (w_match_evt && !r_ctrl.auto_reload) begin
      w_ctrl_nxt.en = 1'b0;
    end else begin
      w_ctrl_nxt = r_ctrl;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_count) begin
      w_count_nxt = dbus.dat_o;
    end else if (w_tick) begin
      if (w_cmp_eq) begin
        w_count_nxt = r_ctrl.auto_reload ? 16'h0000 : r_count;
      end else begin
        w_count_nxt = r_count + 16'd1;
      end
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Status flags: a new match beats a same-cycle write-1-to-clear.
  always_comb begin
    w_compare_nxt = r_compare;
    w_match_nxt   = r_match;
    w_ovr_nxt     = r_ovr;
    if (w_wr_compare) begin
      w_compare_nxt = dbus.dat_o;
    end else begin
      w_compare_nxt = r_compare;
    end
    if (w_match_evt) begin
      w_match_nxt = 1'b1;
    end else if (w_wr_status && dbus.dat_o[STAT_MATCH_BIT]) begin
      w_match_nxt = 1'b0;
    end else begin
      w_match_nxt = r_match;
    end
    if (w_match_evt && r_match) begin
      w_ovr_nxt = 1'b1;
    end else if (w_wr_status && dbus.dat_o[STAT_OVR_BIT]) begin
      w_ovr_nxt = 1'b0;
    end else begin
      w_ovr_nxt = r_ovr;
    end
  end

  always_comb begin
    w_rd_data = 16'h0000;
    case (w_off)
      TMR_CTRL:    w_rd_data = r_ctrl;
      TMR_COUNT:   w_rd_data = r_count;
      TMR_COMPARE: w_rd_data = r_compare;
      TMR_STATUS:  w_rd_data = status_word(r_match, r_ovr);
      default:     w_rd_data = 16'h0000;
    endcase
    if (dbus.re && w_sel) begin
      w_dat_nxt = w_rd_data;
    end else begin
      w_dat_nxt = 16'h0000;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl    <= ctrl_t'(16'h0000);
      r_count   <= 16'h0000;
      r_compare <= 16'h0000;
      r_match   <= 1'b0;
      r_ovr     <= 1'b0;
      r_dat_i   <= 16'h0000;
      r_irq     <= 1'b0;
    end else begin
      r_ctrl    <= w_ctrl_nxt;
      r_count   <= w_count_nxt;
      r_compare <= w_compare_nxt;
      r_match   <= w_match_nxt;
      r_ovr     <= w_ovr_nxt;
      r_dat_i   <= w_dat_nxt;
      r_irq     <= r_match & r_ctrl.irq_en;
    end
  end

  assign dbus.dat_i = r_dat_i;
  assign irq        = r_irq;

endmodule

// File: tb/tb_dbus_timer.sv
// Directed self-checking bench for dbus_timer; inputs change on the falling
// edge and outputs are sampled there, half a cycle away from the active edge.
`timescale 1ns/1ps
module tb_dbus_timer;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        irq;
  logic [15:0] rdat;
  int          n_tests = 0;
  int          n_fail  = 0;

  if_dbus bus ();

  dbus_timer #(.BASE(16'h4000)) dut (
    .clk   (clk),
    .reset (reset),
    .dbus  (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Both bus tasks start at a falling edge and return at the next one.
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.adr   = a;
    bus.dat_o = d;
    bus.we    = 1'b1;
    @(negedge clk);
    bus.we    = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    bus.adr = a;
    bus.re  = 1'b1;
    @(negedge clk);
    bus.re  = 1'b0;
    d       = bus.dat_i;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.adr   = 16'h0000;
    bus.dat_o = 16'h0000;
    bus.re    = 1'b0;
    bus.we    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_dat_i", bus.dat_i, 16'h0000);
    chk("rst_irq", {15'h0000, irq}, 16'h0000);

    // Reset while COUNT holds 0x0123, irq is high and a read is in flight.
    wr(16'h4001, 16'h0123);
    wr(16'h4002, 16'h0123);
    wr(16'h4000, 16'h0005);
    repeat (2) @(negedge clk);
    chk("pre_rst_irq", {15'h0000, irq}, 16'h0001);
    rd(16'h4001, rdat);
    chk("pre_rst_count", rdat, 16'h0123);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_dat_i", bus.dat_i, 16'h0000);
    chk("async_rst_irq", {15'h0000, irq}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    rd(16'h4000, rdat); chk("rst_ctrl", rdat, 16'h0000);
    rd(16'h4001, rdat); chk("rst_count", rdat, 16'h0000);
    rd(16'h4002, rdat); chk("rst_compare", rdat, 16'h0000);
    rd(16'h4003, rdat); chk("rst_status", rdat, 16'h0000);

    // Read latency: data only in the cycle after the strobe.
    wr(16'h4002, 16'hBEEF);
    bus.adr = 16'h4002;
    bus.re  = 1'b1;
    chk("lat_cycle_n", bus.dat_i, 16'h0000);
    @(negedge clk);
    bus.re = 1'b0;
    chk("lat_cycle_n1", bus.dat_i, 16'hBEEF);
    @(negedge clk);
    chk("lat_cycle_n2", bus.dat_i, 16'h0000);
    rd(16'h4004, rdat); chk("unselected_read", rdat, 16'h0000);
    bus.adr   = 16'h4002;
    bus.dat_o = 16'h1234;
    bus.re    = 1'b1;
    bus.we    = 1'b1;
    @(negedge clk);
    bus.re = 1'b0;
    bus.we = 1'b0;
    chk("rw_same_cycle_old", bus.dat_i, 16'hBEEF);
    rd(16'h4002, rdat); chk("rw_same_cycle_new", rdat, 16'h1234);

    // Auto-reload, PRESCALE 2: COUNT traced every cycle via back-to-back reads.
    wr(16'h4002, 16'h0003);
    wr(16'h4000, 16'h0207);
    bus.adr = 16'h4001;
    bus.re  = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk($sformatf("ar_count_%0d", i), bus.dat_i, 16'((i / 3) % 4));
      chk($sformatf("ar_irq_%0d", i), {15'h0000, irq}, (i >= 12) ? 16'h0001 : 16'h0000);
    end
    bus.adr = 16'h4003;
    @(negedge clk);
    bus.re = 1'b0;
    chk("ar_first_match_status", bus.dat_i, 16'h0001);
    repeat (10) @(negedge clk);
    rd(16'h4003, rdat); chk("ar_ovr_status", rdat, 16'h0003);
    chk("ar_irq_held", {15'h0000, irq}, 16'h0001);
    wr(16'h4000, 16'h0000);
    wr(16'h4003, 16'h0003);
    wr(16'h4001, 16'h0000);

    // One-shot: stops at COMPARE, EN self-clears, no irq without IRQ_EN.
    wr(16'h4002, 16'h0002);
    wr(16'h4000, 16'h0001);
    repeat (5) @(negedge clk);
    rd(16'h4001, rdat); chk("os_count", rdat, 16'h0002);
    rd(16'h4000, rdat); chk("os_ctrl", rdat, 16'h0000);
    rd(16'h4003, rdat); chk("os_status", rdat, 16'h0001);
    chk("os_irq", {15'h0000, irq}, 16'h0000);

    // W1C of MATCH in the match-tick cycle loses to the set.
    wr(16'h4003, 16'h0003);
    wr(16'h4001, 16'h0000);
    wr(16'h4000, 16'h0005);
    repeat (2) @(negedge clk);
    wr(16'h4003, 16'h0001);
    rd(16'h4003, rdat); chk("w1c_vs_set", rdat, 16'h0001);
    chk("w1c_irq_high", {15'h0000, irq}, 16'h0001);
    wr(16'h4003, 16'h0003);
    chk("w1c_irq_lag", {15'h0000, irq}, 16'h0001);
    @(negedge clk);
    chk("w1c_irq_drop", {15'h0000, irq}, 16'h0000);
    rd(16'h4003, rdat); chk("w1c_status", rdat, 16'h0000);

    // COUNT write coincident with a tick wins.
    wr(16'h4002, 16'h1000);
    wr(16'h4001, 16'h0000);
    wr(16'h4000, 16'h0001);
    wr(16'h4001, 16'h0010);
    rd(16'h4001, rdat); chk("wr_vs_tick", rdat, 16'h0010);
    rd(16'h4001, rdat); chk("after_wr_tick", rdat, 16'h0011);

    // Wrap 0xFFFF -> 0 without a match.
    wr(16'h4000, 16'h0000);
    wr(16'h4002, 16'h0005);
    wr(16'h4003, 16'h0003);
    wr(16'h4001, 16'hFFFF);
    wr(16'h4000, 16'h0001);
    rd(16'h4001, rdat); chk("wrap_pre", rdat, 16'hFFFF);
    rd(16'h4001, rdat); chk("wrap_zero", rdat, 16'h0000);
    rd(16'h4003, rdat); chk("wrap_no_match", rdat, 16'h0000);
    wr(16'h4000, 16'h0000);

    // Reserved CTRL bits read as zero.
    wr(16'h4000, 16'hA5F8);
    rd(16'h4000, rdat); chk("ctrl_rsvd", rdat, 16'hA500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_timer.md
Name: dbus_timer

Overview:
- Memory-mapped 16-bit timer/compare peripheral; responder (slave) on the J1 data bus.
- Sits beside data RAM on `if_dbus`.
- Serves the core's single-cycle `re`/`we` strobes with a fixed one-cycle read latency.
- Raises a level interrupt on compare match.

Parameters:
- `BASE`, 16'h4000: word address of register 0; `BASE[1:0]` must be 2'b00; block occupies words `BASE..BASE+3`.

Ports:
- `clk` input 1: clock.
- `reset` input 1: asynchronous, active-high reset.
- `dbus` `if_dbus.slave` (bundle):
  - samples `adr[15:0]` (word address), `re`, `we`, `dat_o[15:0]` (write data);
  - drives `dat_i[15:0]` (read data).
- `irq` output 1: interrupt, `STATUS.MATCH & CTRL.IRQ_EN`, registered.

Behaviour:
- Clocking and reset:
  - One clock `clk`; reset is asynchronous, active-high.
  - All registers, `dat_i` and `irq` clear to 0 on reset.
  - Reset mid-count or mid-access aborts immediately; no pending state survives.
- Select:
  - `sel = (adr[15:2] == BASE[15:2])`; offset `adr[1:0]`.
- Write:
  - `we & sel` in cycle N updates the addressed register at the edge ending cycle N.
- Read:
  - `re & sel` in cycle N registers the addressed value.
  - `dat_i` holds it during cycle N+1 only (the core's wait cycle); `dat_i` = 16'h0 in all other cycles, so it can be OR-combined with other slaves.
  - Unselected or idle: `dat_i` = 0.
  - `re` and `we` in the same cycle: write performed; read returns the pre-write value.
- Register map:
  - 0 `CTRL`: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN, [7:3] reads 0, [15:8] PRESCALE.
  - 1 `COUNT`: current count; a write loads it.
  - 2 `COMPARE`: match value.
  - 3 `STATUS`: [0] MATCH, [1] OVR, rest read 0. Write-1-to-clear; writing 0 has no effect.
- Prescaler:
  - 8-bit counter `pre`; `tick` when `EN & pre == PRESCALE`, and then `pre` <= 0; else `pre` <= `pre`+1 while EN.
  - PRESCALE = 0 gives a tick every cycle.
  - Any `CTRL` write clears `pre`; EN = 0 holds `pre` at 0.
- Count on tick:
  - If `COUNT == COMPARE`: set MATCH; set OVR if MATCH was already 1. Then:
    - AUTO_RELOAD = 1: `COUNT` <= 0.
    - AUTO_RELOAD = 0: `COUNT` holds and EN clears (one-shot).
  - Else `COUNT` <= `COUNT`+1, wrapping 16'hFFFF -> 0 with no flag.
- Simultaneous events:
  - `COUNT` write and tick in the same cycle: write wins, no increment, no match evaluated.
  - `CTRL` write and tick: the tick uses the old CTRL; new CTRL takes effect next cycle. If the tick's one-shot clears EN and the write sets EN, the write wins.
  - `STATUS` W1C and a new match in the same cycle: set wins.
  - `COMPARE` write: takes effect for the next tick.
- `irq`:
  - registered; asserts 1 cycle after MATCH sets (with IRQ_EN = 1).
  - drops 1 cycle after MATCH clears or IRQ_EN clears.

Decomposition:
- Package `types`:
  - `timer_reg_t` enum: `TMR_CTRL`=0, `TMR_COUNT`=1, `TMR_COMPARE`=2, `TMR_STATUS`=3.
  - CTRL/STATUS bit-position localparams.
  - `ctrl_t` packed struct: prescale[7:0], rsvd[4:0], irq_en, auto_reload, en.
- One sub-module `timer_prescaler` (inputs `en`, `clr`, `prescale`; output `tick`).
- Decode, registers and read mux stay in `dbus_timer`.

Test Plan:
- Reset:
  - assert reset mid-count (`COUNT` = 16'h0123) -> all regs, `dat_i`, `irq` = 0 asynchronously.
  - read each offset after release -> 0.
- Read latency:
  - write `COMPARE` = 16'hBEEF, then `re` at `adr` = 16'h4002 in cycle N -> `dat_i` = 16'hBEEF exactly in N+1, 0 in N and N+2.
  - `re` at `adr` = 16'h4004 -> `dat_i` stays 0.
- Auto-reload with prescale:
  - `COMPARE` = 3, `CTRL` = 16'h0207 (PRESCALE 2, EN, AR, IRQ_EN) -> `COUNT` steps every 3 cycles: 0,1,2,3,0.
  - MATCH sets on the 3->0 tick; `irq` rises the next cycle.
  - second match without clear -> OVR = 1.
- One-shot:
  - `CTRL` = 16'h0001, `COMPARE` = 2 -> `COUNT` stops at 2; EN reads 0; MATCH = 1; `irq` stays 0 (IRQ_EN = 0).
- W1C vs. set:
  - write `STATUS` = 16'h0001 in the same cycle as a match tick -> MATCH remains 1.
  - write 16'h0003 in an idle cycle -> `STATUS` reads 0; `irq` drops 1 cycle later.
- Collisions:
  - `COUNT` write 16'h0010 coincident with a tick -> next read = 16'h0010.
  - `COUNT` = 16'hFFFF, `COMPARE` = 16'h0005 -> wraps to 0, no MATCH.
